idli_ibuf_m: RTL and testbench
==============================

# idli_ibuf_m

Nibble-serial instruction buffer between the SQI memory controller and the decoder. It captures 4-bit read nibbles from the SQI block, which cannot be stalled mid-burst. It stores them in a small circular FIFO and presents them to the decoder with a valid/ready handshake, tagging the nibble that completes each 16-bit instruction. It gives the SQI controller a word-granular space indication so that a new 16-bit fetch starts only when the whole word can be absorbed.

## Interface

Parameters:
- `DEPTH`, default 4: buffer capacity in 16-bit words; power of two, ≥ 1; storage is `DEPTH*4` nibbles.

Ports:
- `i_ibuf_gck`, input, 1: core clock; all state updates on the rising edge.
- `i_ibuf_rst`, input, 1: reset, synchronous, active-high.
- `i_ibuf_sqi_data`, input, 4: nibble from SQI, type `sqi_data_t`.
- `i_ibuf_sqi_vld`, input, 1: `i_ibuf_sqi_data` valid this cycle; no back-pressure.
- `o_ibuf_space`, output, 1: at least 4 free nibble slots; SQI may start a new word.
- `i_ibuf_flush`, input, 1: discard all buffered nibbles (branch redirect).
- `o_ibuf_enc`, output, 4: nibble to decoder.
- `o_ibuf_enc_vld`, output, 1: `o_ibuf_enc` valid.
- `i_ibuf_enc_rdy`, input, 1: decoder accepts nibble.
- `o_ibuf_enc_last`, output, 1: `o_ibuf_enc` is nibble 3 (most significant) of its instruction word.
- `o_ibuf_ovf`, output, 1: sticky overflow error.

## Operation

- Storage: `DEPTH*4` × 4-bit array, write pointer and read pointer each `$clog2(DEPTH*4)+1` bits.
  - The MSB of each pointer is the wrap bit.
  - Empty when the pointers are fully equal.
  - Full when the low bits are equal and the wrap bits differ.
  - Pointers wrap modulo `2*DEPTH*4`.
- Write: `i_ibuf_sqi_vld` and not full and not flush stores the nibble at the write pointer and increments the pointer.
- Overflow: `i_ibuf_sqi_vld` while full drops the nibble and sets `o_ibuf_ovf`. The flag clears only on reset.
- Read: `o_ibuf_enc` = array[read pointer]. `o_ibuf_enc_vld` = not empty. A pop occurs when `o_ibuf_enc_vld && i_ibuf_enc_rdy`.
- Word position: a 2-bit counter `pos` increments on each pop and wraps 3→0. `o_ibuf_enc_last` = `o_ibuf_enc_vld && pos == 3`. Nibble order is least significant first, matching the SQI stream.
- Space: `o_ibuf_space` = (`DEPTH*4` − occupancy) ≥ 4. It is computed from registered pointers and does not account for a same-cycle pop.
- Flush: `i_ibuf_flush` has priority over a write and a pop in the same cycle.
  - It sets both pointers to 0 and `pos` to 0.
  - The same-cycle SQI nibble is discarded.
  - The same-cycle pop is not counted.
  - `o_ibuf_ovf` is unaffected.
- Simultaneous write and pop while full: the write is dropped as overflow. Fullness is evaluated before the pop.
- Simultaneous write and pop while not full: both occur and occupancy is unchanged.

## Timing

- Reset values:
  - `o_ibuf_enc_vld` = 0, `o_ibuf_enc_last` = 0, `o_ibuf_ovf` = 0, `o_ibuf_space` = 1.
  - `o_ibuf_enc` = 0 (storage cleared).
  - Pointers = 0, `pos` = 0.
- Reset mid-burst: identical to the reset state on the next cycle. Any nibble presented in the reset cycle is discarded.
- Latency: a nibble written at edge N is valid on `o_ibuf_enc` in the cycle following N.
- Throughput: one write and one pop per cycle, sustained.
- After flush at edge N: `o_ibuf_enc_vld` = 0 and `o_ibuf_space` = 1 in the following cycle.
- `o_ibuf_space` deasserts in the cycle after the write that leaves fewer than 4 free slots.

## Configuration

- `IDLI_IBUF_BYPASS_EN` defined:
  - When the buffer is empty, `i_ibuf_sqi_vld` = 1, `i_ibuf_rdy` (`i_ibuf_enc_rdy`) = 1 and there is no flush, the incoming nibble drives `o_ibuf_enc` combinationally with `o_ibuf_enc_vld` = 1. Latency is 0.
  - The nibble is consumed without being written, and `pos` advances.
  - If `i_ibuf_enc_rdy` = 0, the nibble is written normally.
- `IDLI_IBUF_BYPASS_EN` undefined: no combinational path from SQI inputs to decoder outputs; latency is always 1 cycle.

## Test plan

- Reset, then 4 nibbles 0x1,0x2,0x3,0x4 with `i_ibuf_enc_rdy` = 1 → output 1,2,3,4 each one cycle after write (same cycle with bypass); `o_ibuf_enc_last` only on 0x4.
- `DEPTH` = 2, `rdy` = 0, write 8 nibbles → `o_ibuf_space` falls after the 5th write. A 9th nibble sets `o_ibuf_ovf`, and the drain yields exactly the 8 original nibbles.
- Fill to full, then a write and a pop in the same cycle → the write is dropped, `o_ibuf_ovf` = 1, and occupancy becomes 7.
- Write 6 nibbles, pop 2, assert flush together with a write → next cycle `o_ibuf_enc_vld` = 0 and `space` = 1. A subsequent word has `last` on its 4th nibble.
- Random valid/ready over 1000 nibbles with pointer wrap → the output sequence equals the input sequence, and `last` is on every 4th popped nibble.
- Assert `i_ibuf_rst` with 3 nibbles buffered and `ovf` = 1 → next cycle all outputs are at reset values.

Source files
------------

// File: rtl/idli_ibuf_m_if.sv
`default_nettype none
//==============================================================================
// Module      : idli_ibuf_m_if
// Description : SQI-side nibble stream and decoder-side valid/ready bundle
//               for the idli instruction buffer.
// Revision    : 1.0 - initial release
//==============================================================================
interface idli_ibuf_m_if;

    typedef logic [3:0] sqi_data_t;

    sqi_data_t i_ibuf_sqi_data;
    logic      i_ibuf_sqi_vld;
    logic      o_ibuf_space;
    logic      i_ibuf_flush;
    sqi_data_t o_ibuf_enc;
    logic      o_ibuf_enc_vld;
    logic      i_ibuf_enc_rdy;
    logic      o_ibuf_enc_last;
    logic      o_ibuf_ovf;

    // Buffer side
    modport slave (
        input  i_ibuf_sqi_data,
        input  i_ibuf_sqi_vld,
        output o_ibuf_space,
        input  i_ibuf_flush,
        output o_ibuf_enc,
        output o_ibuf_enc_vld,
        input  i_ibuf_enc_rdy,
        output o_ibuf_enc_last,
        output o_ibuf_ovf
    );

    // SQI controller / decoder side
    modport master (
        output i_ibuf_sqi_data,
        output i_ibuf_sqi_vld,
        input  o_ibuf_space,
        output i_ibuf_flush,
        input  o_ibuf_enc,
        input  o_ibuf_enc_vld,
        output i_ibuf_enc_rdy,
        input  o_ibuf_enc_last,
        input  o_ibuf_ovf
    );

endinterface
`default_nettype wire

// File: rtl/idli_ibuf_m.sv
`default_nettype none
//==============================================================================
// Module      : idli_ibuf_m
// Description : Nibble-serial instruction buffer between the SQI controller
//               and the decoder. Circular FIFO of DEPTH*4 nibbles with
//               word-granular space indication and last-nibble tagging.
//               Define IDLI_IBUF_BYPASS_EN for a zero-latency empty-buffer
//               bypass from SQI to decoder.
// Revision    : 1.0 - initial release
//==============================================================================
module idli_ibuf_m #(
    parameter int DEPTH = 4
) (
    input  logic          i_ibuf_gck,
    input  logic          i_ibuf_rst,
    idli_ibuf_m_if.slave  ibuf
);

    localparam int c_NIB        = DEPTH * 4;
    localparam int c_AW         = $clog2(c_NIB);
    localparam int c_PW         = c_AW + 1;
    localparam int c_WORD_NIBS  = 4;
    localparam logic [c_PW-1:0] c_PTR_ONE = c_PW'(1);

    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [3:0]      r_mem [c_NIB];
    logic [1:0]      r_pos;
    logic            r_ovf;

    logic [c_AW-1:0] w_wr_idx;
    logic [c_AW-1:0] w_rd_idx;
    logic [c_PW-1:0] w_occ;
    logic [3:0]      w_data;
    logic            w_sqi_vld;
    logic            w_rdy;
    logic            w_flush;
    logic            w_empty;
    logic            w_full;
    logic            w_bypass;
    logic            w_vld;
    logic            w_wr_en;
    logic            w_rd_en;
    logic            w_pop;
    logic            w_drop;

    assign w_data    = ibuf.i_ibuf_sqi_data;
    assign w_sqi_vld = ibuf.i_ibuf_sqi_vld;
    assign w_rdy     = ibuf.i_ibuf_enc_rdy;
    assign w_flush   = ibuf.i_ibuf_flush;

    assign w_wr_idx = r_wr_ptr[c_AW-1:0];
    assign w_rd_idx = r_rd_ptr[c_AW-1:0];
    assign w_occ    = r_wr_ptr - r_rd_ptr;

    // Wrap bit disambiguates full from empty when the index bits match
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (w_wr_idx == w_rd_idx) && (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]);

`ifdef IDLI_IBUF_BYPASS_EN
    assign w_bypass = w_empty & w_sqi_vld & w_rdy & ~w_flush;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_vld   = ~w_empty | w_bypass;
    assign w_wr_en = w_sqi_vld & ~w_full & ~w_flush & ~w_bypass;
    assign w_drop  = w_sqi_vld & w_full & ~w_flush;
    assign w_rd_en = ~w_empty & w_rdy & ~w_flush;
    assign w_pop   = w_vld & w_rdy & ~w_flush;

    assign ibuf.o_ibuf_enc      = w_bypass ? w_data : r_mem[w_rd_idx];
    assign ibuf.o_ibuf_enc_vld  = w_vld;
    assign ibuf.o_ibuf_enc_last = w_vld & (r_pos == 2'd3);
    assign ibuf.o_ibuf_ovf      = r_ovf;
    // Registered occupancy only; a same-cycle pop does not open space early
    assign ibuf.o_ibuf_space    = (c_NIB - int'(w_occ)) >= c_WORD_NIBS;

    always_ff @(posedge i_ibuf_gck) begin
        if (i_ibuf_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    always_ff @(posedge i_ibuf_gck) begin
        if (i_ibuf_rst) begin
            for (int i = 0; i < c_NIB; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[w_wr_idx] <= w_data;
        end
    end

    always_ff @(posedge i_ibuf_gck) begin
        if (i_ibuf_rst || w_flush) begin
            r_pos <= 2'd0;
        end else if (w_pop) begin
            r_pos <= r_pos + 2'd1;
        end
    end

    always_ff @(posedge i_ibuf_gck) begin
        if (i_ibuf_rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_idli_ibuf_m.sv
`default_nettype none
//==============================================================================
// Module      : tb_idli_ibuf_m
// Description : Self-checking bench for idli_ibuf_m against a queue model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_idli_ibuf_m;

    localparam int DEPTH = 2;
    localparam int C_N   = DEPTH * 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sqi_data = 4'h0;
    logic       sqi_vld  = 1'b0;
    logic       flush    = 1'b0;
    logic       rdy      = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] mq[$];
    int         mpos = 0;
    bit         movf = 1'b0;

    always #5 clk = ~clk;

    idli_ibuf_m_if bus();

    assign bus.i_ibuf_sqi_data = sqi_data;
    assign bus.i_ibuf_sqi_vld  = sqi_vld;
    assign bus.i_ibuf_flush    = flush;
    assign bus.i_ibuf_enc_rdy  = rdy;

    idli_ibuf_m #(.DEPTH(DEPTH)) dut (
        .i_ibuf_gck (clk),
        .i_ibuf_rst (rst),
        .ibuf       (bus)
    );

    function automatic bit model_bypass();
`ifdef IDLI_IBUF_BYPASS_EN
        return (mq.size() == 0) && sqi_vld && rdy && !flush;
`else
        return 1'b0;
`endif
    endfunction

    // {vld, last, space, ovf, enc} expected in the current cycle
    function automatic logic [7:0] model_expect();
        bit         bp = model_bypass();
        bit         v  = (mq.size() != 0) || bp;
        logic [3:0] e  = 4'h0;
        if (mq.size() != 0) e = mq[0];
        else if (bp)        e = sqi_data;
        return {v, v && (mpos == 3), (C_N - mq.size()) >= 4, movf, e};
    endfunction

    function automatic logic [7:0] observed();
        logic v = bus.o_ibuf_enc_vld;
        return {v, bus.o_ibuf_enc_last, bus.o_ibuf_space, bus.o_ibuf_ovf,
                v ? bus.o_ibuf_enc : 4'h0};
    endfunction

    function automatic void model_update();
        bit bp;
        bit v;
        bit full;
        if (rst) begin
            mq.delete(); mpos = 0; movf = 1'b0;
            return;
        end
        if (flush) begin
            mq.delete(); mpos = 0;
            return;
        end
        bp   = model_bypass();
        v    = (mq.size() != 0) || bp;
        full = (mq.size() == C_N);
        if (v && rdy) begin
            if (!bp) void'(mq.pop_front());
            mpos = (mpos + 1) % 4;
        end
        if (sqi_vld && !bp) begin
            if (full) movf = 1'b1;
            else      mq.push_back(sqi_data);
        end
    endfunction

    task automatic drive(input bit v, input logic [3:0] d, input bit r, input bit f);
        sqi_vld = v; sqi_data = d; rdy = r; flush = f;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive(0, 4'h0, 0, 0);
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        rst = 1'b1;
        drive(1, 4'hA, 1, 0);
        step(); step();
        rst = 1'b0;
        drive(0, 4'h0, 0, 0);
        #3;
        obs = {bus.o_ibuf_enc_vld, bus.o_ibuf_enc_last, bus.o_ibuf_space,
               bus.o_ibuf_ovf, bus.o_ibuf_enc};
        n_vec++;
        if (obs !== 8'b0010_0000) begin
            n_err++;
            $display("FAIL reset_state: got %h expected %h", obs, 8'b0010_0000);
        end
    endtask

    task automatic test_basic();
        logic [7:0] obs, exp;
        for (int i = 0; i < 8; i++) begin
            drive(i < 4, 4'(i + 1), 1, 0);
            #3;
            exp = model_expect(); obs = observed(); n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL basic[%0d]: got %h expected %h", i, obs, exp);
            end
            step();
        end
    endtask

    task automatic test_overflow();
        logic [7:0] obs, exp;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            if (i < 9) drive(1, 4'($urandom), 0, 0);
            else       drive(0, 4'h0, 1, 0);
            #3;
            exp = model_expect(); obs = observed(); n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL overflow[%0d]: got %h expected %h", i, obs, exp);
            end
            step();
        end
    endtask

    task automatic test_full_pop();
        logic [7:0] obs, exp;
        int pops = 0;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            if (i < 8)       drive(1, 4'($urandom), 0, 0);
            else if (i == 8) drive(1, 4'($urandom), 1, 0);
            else             drive(0, 4'h0, 1, 0);
            #3;
            exp = model_expect(); obs = observed(); n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL full_pop[%0d]: got %h expected %h", i, obs, exp);
            end
            if (i > 8 && bus.o_ibuf_enc_vld) pops++;
            step();
        end
        n_vec++;
        if (pops !== 7) begin
            n_err++;
            $display("FAIL full_pop_occupancy: got %0d expected 7", pops);
        end
    endtask

    task automatic test_flush();
        logic [7:0] obs, exp;
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            if (i < 6)       drive(1, 4'($urandom), 0, 0);
            else if (i < 8)  drive(0, 4'h0, 1, 0);
            else if (i == 8) drive(1, 4'($urandom), 1, 1);
            else             drive(i < 13, 4'($urandom), 1, 0);
            #3;
            exp = model_expect(); obs = observed(); n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL flush[%0d]: got %h expected %h", i, obs, exp);
            end
            step();
        end
    endtask

    task automatic test_random();
        logic [7:0] obs, exp;
        int sent = 0;
        int burst = 0;
        int cyc = 0;
        apply_reset();
        while (sent < 1000 && cyc < 6000) begin
            if (burst == 0 && bus.o_ibuf_space && ($urandom % 3 != 0)) burst = 4;
            drive(burst > 0, 4'($urandom), ($urandom % 4) != 0, 0);
            #3;
            exp = model_expect(); obs = observed(); n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL random[%0d]: got %h expected %h", cyc, obs, exp);
            end
            step();
            if (burst > 0) begin
                burst--; sent++;
            end
            cyc++;
        end
        n_vec++;
        if (sent < 1000) begin
            n_err++;
            $display("FAIL random_timeout: got %0d nibbles expected 1000", sent);
        end
        for (int i = 0; i < 12; i++) begin
            drive(0, 4'h0, 1, 0);
            #3;
            exp = model_expect(); obs = observed(); n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL random_drain[%0d]: got %h expected %h", i, obs, exp);
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] obs, exp;
        apply_reset();
        for (int i = 0; i < 14; i++) begin
            if (i < 9) drive(1, 4'($urandom), 0, 0);
            else       drive(0, 4'h0, 1, 0);
            #3;
            exp = model_expect(); obs = observed(); n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL reset_mid_fill[%0d]: got %h expected %h", i, obs, exp);
            end
            step();
        end
        rst = 1'b1;
        drive(1, 4'h9, 1, 0);
        step();
        rst = 1'b0;
        drive(0, 4'h0, 0, 0);
        #3;
        obs = {bus.o_ibuf_enc_vld, bus.o_ibuf_enc_last, bus.o_ibuf_space,
               bus.o_ibuf_ovf, bus.o_ibuf_enc};
        n_vec++;
        if (obs !== 8'b0010_0000) begin
            n_err++;
            $display("FAIL reset_mid: got %h expected %h", obs, 8'b0010_0000);
        end
        step();
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop();
        test_flush();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
